// File: rtl/hifigan_conv_sequencer.sv
// Job-level sequencer for the 1-D convolution MAC: walks cout/t/cin, issues SRAM reads,
// drives MAC controls and holds one result slot. Optional macro: HIFIGAN_SEQ_LEAKY_RELU_EN.
module hifigan_conv_sequencer #(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = 16,
    parameter int CH_W        = 8,
    parameter int LEN_W       = 12,
    parameter int ADDR_W      = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [CH_W-1:0]       i_num_cin,
    input  logic [CH_W-1:0]       i_num_cout,
    input  logic [LEN_W-1:0]      i_num_samples,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_act_rd,
    output logic [ADDR_W-1:0]     o_act_addr,
    output logic                  o_wgt_rd,
    output logic [ADDR_W-1:0]     o_wgt_addr,
    output logic                  o_calc_en,
    output logic                  o_clear_acc,
    input  logic [DATA_WIDTH-1:0] i_mac_result,
    input  logic                  i_mac_valid,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic [CH_W-1:0]       o_out_ch,
    output logic [LEN_W-1:0]      o_out_idx
);

    if (KERNEL_SIZE < 1) begin : g_bad_kernel
        $error("KERNEL_SIZE must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;
    state_t state, state_nx;

    logic [CH_W-1:0]       num_cin, num_cout, cin, cout;
    logic [LEN_W-1:0]      num_samples, t;
    logic [ADDR_W-1:0]     act_addr, wgt_addr, wgt_base;
    logic                  first, cap1, cap2, calc_q, clear_q;
    logic [CH_W-1:0]       cur_ch, tag1_ch, tag2_ch;
    logic [LEN_W-1:0]      cur_idx, tag1_idx, tag2_idx;
    logic [DATA_WIDTH-1:0] res_mod;

    logic start_ok, zero_cfg, out_busy, cin_first, last_cin, last_t, last_cout;
    logic run_stall, issue, flush_issue, drain_done, capture;

    assign start_ok    = (state == IDLE) && i_start;
    assign zero_cfg    = (i_num_cin == '0) || (i_num_cout == '0) || (i_num_samples == '0);
    assign out_busy    = o_out_valid || cap1 || cap2;
    assign cin_first   = (cin == '0);
    assign last_cin    = (cin == num_cin - CH_W'(1));
    assign last_t      = (t == num_samples - LEN_W'(1));
    assign last_cout   = (cout == num_cout - CH_W'(1));
    // The first clear of a job has no finished point behind it, so it never waits on the slot.
    assign run_stall   = cin_first && !first && out_busy;
    assign issue       = (state == RUN) && !run_stall;
    assign flush_issue = (state == FLUSH) && !out_busy;
    assign drain_done  = (state == DRAIN) && !out_busy;
    assign capture     = cap2 && i_mac_valid;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok) state_nx = zero_cfg ? DRAIN : RUN;
            RUN:     if (issue && last_cin && last_t && last_cout) state_nx = FLUSH;
            FLUSH:   if (flush_issue) state_nx = DRAIN;
            DRAIN:   if (drain_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign o_busy      = (state != IDLE);
    assign o_done      = drain_done;
    assign o_act_rd    = issue;
    assign o_wgt_rd    = issue;
    assign o_act_addr  = act_addr;
    assign o_wgt_addr  = wgt_addr;
    assign o_calc_en   = calc_q;
    assign o_clear_acc = clear_q;

`ifdef HIFIGAN_SEQ_LEAKY_RELU_EN
    assign res_mod = i_mac_result[DATA_WIDTH-1] ? $unsigned($signed(i_mac_result) >>> 3) : i_mac_result;
`else
    assign res_mod = i_mac_result;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            num_cin     <= '0;
            num_cout    <= '0;
            num_samples <= '0;
            cin         <= '0;
            cout        <= '0;
            t           <= '0;
            act_addr    <= '0;
            wgt_addr    <= '0;
            wgt_base    <= '0;
            first       <= 1'b0;
            cur_ch      <= '0;
            cur_idx     <= '0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                num_cin     <= i_num_cin;
                num_cout    <= i_num_cout;
                num_samples <= i_num_samples;
                cin         <= '0;
                cout        <= '0;
                t           <= '0;
                act_addr    <= '0;
                wgt_addr    <= '0;
                wgt_base    <= '0;
                first       <= 1'b1;
            end else if (issue) begin
                first <= 1'b0;
                if (cin_first) begin
                    cur_ch  <= cout;
                    cur_idx <= t;
                end
                if (last_cin) begin
                    cin <= '0;
                    if (last_t) begin
                        t        <= '0;
                        act_addr <= '0;
                        wgt_base <= wgt_addr + ADDR_W'(1);
                        wgt_addr <= wgt_addr + ADDR_W'(1);
                        if (!last_cout) cout <= cout + CH_W'(1);
                    end else begin
                        t        <= t + LEN_W'(1);
                        act_addr <= ADDR_W'(t) + ADDR_W'(1);
                        wgt_addr <= wgt_base;
                    end
                end else begin
                    cin      <= cin + CH_W'(1);
                    act_addr <= act_addr + ADDR_W'(num_samples);
                    wgt_addr <= wgt_addr + ADDR_W'(1);
                end
            end
        end
    end

    // Two-stage tag/capture pipeline matching memory latency plus the MAC's one-point lag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            calc_q      <= 1'b0;
            clear_q     <= 1'b0;
            cap1        <= 1'b0;
            cap2        <= 1'b0;
            tag1_ch     <= '0;
            tag1_idx    <= '0;
            tag2_ch     <= '0;
            tag2_idx    <= '0;
            o_out_valid <= 1'b0;
            o_out_data  <= '0;
            o_out_ch    <= '0;
            o_out_idx   <= '0;
        end else begin
            calc_q   <= issue || flush_issue;
            clear_q  <= (issue && cin_first) || flush_issue;
            cap1     <= (issue && cin_first && !first) || flush_issue;
            tag1_ch  <= cur_ch;
            tag1_idx <= cur_idx;
            cap2     <= cap1;
            tag2_ch  <= tag1_ch;
            tag2_idx <= tag1_idx;
            if (capture) begin
                o_out_valid <= 1'b1;
                o_out_data  <= res_mod;
                o_out_ch    <= tag2_ch;
                o_out_idx   <= tag2_idx;
            end else if (o_out_valid && i_out_ready) begin
                o_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hifigan_conv_sequencer.sv
// Self-checking bench for hifigan_conv_sequencer with a behavioural SRAM + lagging MAC model.
module tb_hifigan_conv_sequencer;
    localparam int DW = 16, CHW = 8, LW = 12, AW = 20;
`ifdef HIFIGAN_SEQ_LEAKY_RELU_EN
    localparam bit LEAKY = 1'b1;
`else
    localparam bit LEAKY = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic i_start = 1'b0, i_out_ready = 1'b1;
    logic [CHW-1:0] i_num_cin = '0, i_num_cout = '0;
    logic [LW-1:0] i_num_samples = '0;
    logic o_busy, o_done, o_act_rd, o_wgt_rd, o_calc_en, o_clear_acc, o_out_valid;
    logic [AW-1:0] o_act_addr, o_wgt_addr;
    logic [DW-1:0] mac_res, o_out_data;
    logic mac_valid;
    logic [CHW-1:0] o_out_ch;
    logic [LW-1:0] o_out_idx;

    always #5 clk = ~clk;

    hifigan_conv_sequencer dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_num_cin(i_num_cin), .i_num_cout(i_num_cout),
        .i_num_samples(i_num_samples), .o_busy(o_busy), .o_done(o_done), .o_act_rd(o_act_rd),
        .o_act_addr(o_act_addr), .o_wgt_rd(o_wgt_rd), .o_wgt_addr(o_wgt_addr), .o_calc_en(o_calc_en),
        .o_clear_acc(o_clear_acc), .i_mac_result(mac_res), .i_mac_valid(mac_valid),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
        .o_out_ch(o_out_ch), .o_out_idx(o_out_idx)
    );

    logic [15:0] act_mem [0:255];
    logic [15:0] wgt_mem [0:255];
    logic [15:0] act_q, wgt_q;
    logic signed [31:0] acc;
    int mac_k = 3;

    function automatic logic [15:0] sat16(input logic signed [31:0] v);
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    function automatic logic signed [31:0] prod(input logic [15:0] a, input logic [15:0] w, input int k);
        logic signed [31:0] p;
        p = $signed(a) * $signed(w);
        p = p >>> 14;
        return p * k;
    endfunction

    // SRAMs with 1-cycle latency; MAC reports the pre-update accumulator one cycle after a clear.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q <= '0; wgt_q <= '0; acc <= '0; mac_res <= '0; mac_valid <= 1'b0;
        end else begin
            if (o_act_rd) act_q <= act_mem[o_act_addr[7:0]];
            if (o_wgt_rd) wgt_q <= wgt_mem[o_wgt_addr[7:0]];
            mac_valid <= o_calc_en && o_clear_acc;
            if (o_calc_en) begin
                if (o_clear_acc) begin
                    mac_res <= sat16(acc);
                    acc <= prod(act_q, wgt_q, mac_k);
                end else begin
                    acc <= acc + prod(act_q, wgt_q, mac_k);
                end
            end
        end
    end

    int iss_act[$], iss_wgt[$], out_ch[$], out_idx[$];
    logic [15:0] out_d[$];
    int done_cnt = 0, strobe_err = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if (o_act_rd) begin
                iss_act.push_back(int'(o_act_addr));
                iss_wgt.push_back(int'(o_wgt_addr));
            end
            if (o_act_rd != o_wgt_rd) strobe_err++;
            if (o_out_valid && i_out_ready) begin
                out_d.push_back(o_out_data);
                out_ch.push_back(int'(o_out_ch));
                out_idx.push_back(int'(o_out_idx));
            end
            if (o_done) done_cnt++;
        end
    end

    int checks = 0, errors = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input int c, input int co, input int t, input int s, input int k);
        logic signed [31:0] sum;
        logic [15:0] r;
        sum = 0;
        for (int ci = 0; ci < c; ci++) sum += prod(act_mem[ci*s+t], wgt_mem[co*c+ci], k);
        r = sat16(sum);
        if (LEAKY && r[15]) r = $unsigned($signed(r) >>> 3);
        return r;
    endfunction

    typedef struct {
        int c; int n; int s; int k; bit pat;
        logic [15:0] afill; logic [15:0] wfill; int hold; logic [15:0] exp_first;
    } job_t;
    job_t jobs[7];

    task automatic load_job(input job_t j);
        for (int i = 0; i < 256; i++) begin
            act_mem[i] = j.pat ? j.afill + 16'(i * 256) : j.afill;
            wgt_mem[i] = j.pat ? j.wfill + 16'(i * 256) : j.wfill;
        end
        mac_k = j.k;
        iss_act.delete(); iss_wgt.delete(); out_d.delete(); out_ch.delete(); out_idx.delete();
        done_cnt = 0; strobe_err = 0;
    endtask

    task automatic run_job(input job_t j, input bit poke);
        int cyc, hold, tot, ni, no;
        load_job(j);
        @(negedge clk);
        i_num_cin = CHW'(j.c); i_num_cout = CHW'(j.n); i_num_samples = LW'(j.s);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_num_cin = '0; i_num_cout = '0; i_num_samples = '0;
        hold = j.hold; cyc = 0;
        while (done_cnt == 0 && cyc < 3000) begin
            i_start = (poke && cyc == 4);
            if (hold > 0 && out_d.size() >= 1) begin
                i_out_ready = 1'b0; hold--;
            end else begin
                i_out_ready = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        i_start = 1'b0; i_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        tot = j.c * j.n * j.s;
        check("done_pulses", done_cnt, 1);
        check("busy_after_done", int'(o_busy), 0);
        check("strobe_pair", strobe_err, 0);
        check("issue_count", iss_act.size(), tot);
        check("output_count", out_d.size(), j.n * j.s);
        if (out_d.size() > 0) check("first_data", int'(out_d[0]), int'(j.exp_first));
        ni = 0;
        for (int co = 0; co < j.n; co++)
            for (int t = 0; t < j.s; t++)
                for (int ci = 0; ci < j.c; ci++) begin
                    if (ni < iss_act.size()) begin
                        check("act_addr", iss_act[ni], ci * j.s + t);
                        check("wgt_addr", iss_wgt[ni], co * j.c + ci);
                    end
                    ni++;
                end
        no = 0;
        for (int co = 0; co < j.n; co++)
            for (int t = 0; t < j.s; t++) begin
                if (no < out_d.size()) begin
                    check("out_data", int'(out_d[no]), int'(model(j.c, co, t, j.s, j.k)));
                    check("out_ch", out_ch[no], co);
                    check("out_idx", out_idx[no], t);
                end
                no++;
            end
    endtask

    initial begin
        jobs[0] = '{c:1, n:1, s:1, k:3, pat:0, afill:16'h2000, wfill:16'h4000, hold:0, exp_first:16'h6000};
        jobs[1] = '{c:2, n:1, s:1, k:3, pat:0, afill:16'h2000, wfill:16'h4000, hold:0, exp_first:16'h7FFF};
        jobs[2] = '{c:2, n:2, s:3, k:3, pat:1, afill:16'h0400, wfill:16'h4000, hold:0, exp_first:16'h2154};
        jobs[3] = '{c:2, n:2, s:3, k:3, pat:1, afill:16'h0400, wfill:16'h4000, hold:10, exp_first:16'h2154};
        jobs[4] = '{c:1, n:1, s:1, k:1, pat:0, afill:16'hE000, wfill:16'h4000, hold:0,
                    exp_first:(LEAKY ? 16'hFC00 : 16'hE000)};
        jobs[5] = '{c:3, n:1, s:2, k:1, pat:0, afill:16'h1000, wfill:16'hC000, hold:0,
                    exp_first:(LEAKY ? 16'hFA00 : 16'hD000)};
        jobs[6] = '{c:2, n:1, s:2, k:3, pat:0, afill:16'h8000, wfill:16'h4000, hold:0,
                    exp_first:(LEAKY ? 16'hF000 : 16'h8000)};

        repeat (3) @(negedge clk);
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_act_rd", int'(o_act_rd), 0);
        check("rst_out_valid", int'(o_out_valid), 0);
        check("rst_act_addr", int'(o_act_addr), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_job(jobs[i], 1'b0);

        // A start with zero counts while busy must be ignored.
        run_job(jobs[2], 1'b1);

        // Zero-count job completes the cycle after start with no reads.
        load_job(jobs[0]);
        @(negedge clk);
        i_num_cin = 8'd2; i_num_cout = 8'd0; i_num_samples = 12'd3; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("zero_done", int'(o_done), 1);
        @(posedge clk); #1;
        check("zero_done_once", int'(o_done), 0);
        repeat (3) @(negedge clk);
        check("zero_reads", iss_act.size(), 0);
        check("zero_outputs", out_d.size(), 0);

        // Reset mid-job aborts without a done pulse.
        load_job(jobs[2]);
        @(negedge clk);
        i_num_cin = 8'd2; i_num_cout = 8'd2; i_num_samples = 12'd3; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1; #1;
        check("midrst_busy", int'(o_busy), 0);
        check("midrst_act_rd", int'(o_act_rd), 0);
        check("midrst_calc", int'(o_calc_en), 0);
        check("midrst_act_addr", int'(o_act_addr), 0);
        check("midrst_wgt_addr", int'(o_wgt_addr), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("midrst_no_done", done_cnt, 0);
        check("midrst_idle", int'(o_busy), 0);

        run_job(jobs[0], 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
